// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl -- staged reset sequencer for the SoC clock domain.
//
// Purpose:
//   Releases the memory, peripheral and CPU resets in that order, with
//   STAGE_GAP cycles between releases. The sequence starts when rst_i drops.
//   A software or watchdog request re-asserts all three resets for
//   SW_HOLD_CNT cycles and then runs the same sequence again.
//
// Parameters:
//   STAGE_GAP    cycles between successive reset releases (>= 1)
//   SW_HOLD_CNT  cycles all resets stay asserted after an accepted request (>= 1)
//
// Ports:
//   clk_i          in   SoC clock
//   rst_i          in   synchronous, active-high system reset
//   sw_rst_req_i   in   software reset request (pulse or level)
//   wdt_rst_req_i  in   watchdog reset request (pulse or level)
//   mem_rst_o      out  active-high reset to the memory subsystem
//   periph_rst_o   out  active-high reset to peripherals
//   cpu_rst_o      out  active-high reset to the CPU core
//   seq_done_o     out  high once every reset has been released
//   rst_cause_o    out  last reset cause (01 rst_i, 10 sw, 11 wdt)
//   dbg_state_o    out  current FSM state, for debug and checkers
//
// Optional feature:
//   Define RST_SEQ_CAUSE_EN to build the sticky reset-cause register.
//   Without it, rst_cause_o is tied to 2'b00 and no register is built.
//
// Handshake: there is no valid/ready interface. The request inputs are
// plain levels. They are sampled on every edge, and a request is taken on
// any edge where the FSM is not in SW_HOLD.

module rst_seq_ctrl #(
    parameter int STAGE_GAP   = 16,
    parameter int SW_HOLD_CNT = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sw_rst_req_i,
    input  logic       wdt_rst_req_i,
    output logic       mem_rst_o,
    output logic       periph_rst_o,
    output logic       cpu_rst_o,
    output logic       seq_done_o,
    output logic [1:0] rst_cause_o,
    output logic [2:0] dbg_state_o
);

    localparam int MAX_CNT = (STAGE_GAP > SW_HOLD_CNT) ? STAGE_GAP : SW_HOLD_CNT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(SW_HOLD_CNT - 1);

    typedef enum logic [2:0] {
        SEQ_MEM    = 3'd0,
        SEQ_PERIPH = 3'd1,
        SEQ_CPU    = 3'd2,
        RUN        = 3'd3,
        SW_HOLD    = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          req;

    // rst_i leaves SEQ_MEM with no transition edge behind it. The first edge
    // after rst_i drops therefore acts as that entry edge and is not counted.
    // This gives mem_rst_o STAGE_GAP counted edges after rst_i, the same as
    // after an exit from SW_HOLD.
    logic          entry_pending;

    assign req = sw_rst_req_i | wdt_rst_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= SEQ_MEM;
            cnt           <= '0;
            entry_pending <= 1'b1;
            mem_rst_o     <= 1'b1;
            periph_rst_o  <= 1'b1;
            cpu_rst_o     <= 1'b1;
            seq_done_o    <= 1'b0;
        end else if (req && (state != SW_HOLD)) begin
            // Re-assert everything, including stages that were already released.
            state         <= SW_HOLD;
            cnt           <= '0;
            entry_pending <= 1'b0;
            mem_rst_o     <= 1'b1;
            periph_rst_o  <= 1'b1;
            cpu_rst_o     <= 1'b1;
            seq_done_o    <= 1'b0;
        end else begin
            case (state)
                SEQ_MEM: begin
                    if (entry_pending) begin
                        entry_pending <= 1'b0;
                    end else if (cnt == GAP_LAST) begin
                        mem_rst_o <= 1'b0;
                        cnt       <= '0;
                        state     <= SEQ_PERIPH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEQ_PERIPH: begin
                    if (cnt == GAP_LAST) begin
                        periph_rst_o <= 1'b0;
                        cnt          <= '0;
                        state        <= SEQ_CPU;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEQ_CPU: begin
                    if (cnt == GAP_LAST) begin
                        cpu_rst_o  <= 1'b0;
                        seq_done_o <= 1'b1;
                        cnt        <= '0;
                        state      <= RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    cnt <= '0;
                end
                SW_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= SEQ_MEM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // Unused encodings restart the sequence with everything held.
                    state        <= SEQ_MEM;
                    cnt          <= '0;
                    mem_rst_o    <= 1'b1;
                    periph_rst_o <= 1'b1;
                    cpu_rst_o    <= 1'b1;
                    seq_done_o   <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state_o = state;

`ifdef RST_SEQ_CAUSE_EN
    logic [1:0] cause_q;

    // The cause is sticky. It changes only on rst_i or on an accepted request.
    // Requests are not accepted in SW_HOLD, so the cause is frozen there.
    // When both requests arrive together, the watchdog is recorded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cause_q <= 2'b01;
        end else if (req && (state != SW_HOLD)) begin
            cause_q <= wdt_rst_req_i ? 2'b11 : 2'b10;
        end
    end

    assign rst_cause_o = cause_q;
`else
    assign rst_cause_o = 2'b00;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed testbench for rst_seq_ctrl with STAGE_GAP=4 and SW_HOLD_CNT=6.
// Inputs are driven and outputs are sampled at the falling clock edge.
// "Edge n" counts the rising edges after the stimulus point described.

module tb_rst_seq_ctrl;

    localparam int GAP  = 4;
    localparam int HOLD = 6;

    localparam logic [2:0] S_MEM    = 3'd0;
    localparam logic [2:0] S_PERIPH = 3'd1;
    localparam logic [2:0] S_CPU    = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       sw_rst_req_i;
    logic       wdt_rst_req_i;
    logic       mem_rst_o;
    logic       periph_rst_o;
    logic       cpu_rst_o;
    logic       seq_done_o;
    logic [1:0] rst_cause_o;
    logic [2:0] dbg_state_o;

    int total = 0;
    int bad   = 0;

    rst_seq_ctrl #(
        .STAGE_GAP  (GAP),
        .SW_HOLD_CNT(HOLD)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sw_rst_req_i (sw_rst_req_i),
        .wdt_rst_req_i(wdt_rst_req_i),
        .mem_rst_o    (mem_rst_o),
        .periph_rst_o (periph_rst_o),
        .cpu_rst_o    (cpu_rst_o),
        .seq_done_o   (seq_done_o),
        .rst_cause_o  (rst_cause_o),
        .dbg_state_o  (dbg_state_o)
    );

    // Clock block
    always #5 clk_i = ~clk_i;

    // Expected cause: the real code when the cause register is built, else 00.
    function automatic logic [1:0] exp_cause(input logic [1:0] c);
`ifdef RST_SEQ_CAUSE_EN
        return c;
`else
        return 2'b00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic chk_rst(input string tag, input logic m, input logic p, input logic c, input logic d);
        chk({tag, ".mem"},    mem_rst_o,    m);
        chk({tag, ".periph"}, periph_rst_o, p);
        chk({tag, ".cpu"},    cpu_rst_o,    c);
        chk({tag, ".done"},   seq_done_o,   d);
    endtask

    logic seen_done;
    logic seen_cpu_low;

    initial begin
        // Reset block
        rst_i         = 1'b1;
        sw_rst_req_i  = 1'b0;
        wdt_rst_req_i = 1'b0;
        tick(5);
        chk_rst("reset", 1, 1, 1, 0);
        chk("reset.state", dbg_state_o, S_MEM);
        chk("reset.cause", rst_cause_o, exp_cause(2'b01));

        // 1) Release from rst_i: edge 0 is the next rising edge.
        rst_i = 1'b0;
        tick(4);                                   // after edge 3
        chk_rst("e3", 1, 1, 1, 0);
        tick(1);                                   // edge 4
        chk_rst("e4", 0, 1, 1, 0);
        tick(3);                                   // edge 7
        chk_rst("e7", 0, 1, 1, 0);
        tick(1);                                   // edge 8
        chk_rst("e8", 0, 0, 1, 0);
        tick(3);                                   // edge 11
        chk_rst("e11", 0, 0, 1, 0);
        tick(1);                                   // edge 12
        chk_rst("e12", 0, 0, 0, 1);
        chk("e12.state", dbg_state_o, S_RUN);
        chk("e12.cause", rst_cause_o, exp_cause(2'b01));

        // 2) One-cycle sw request in RUN, accepted at edge E.
        sw_rst_req_i = 1'b1;
        tick(1);                                   // E
        sw_rst_req_i = 1'b0;
        chk_rst("sw.E", 1, 1, 1, 0);
        chk("sw.E.state", dbg_state_o, S_HOLD);
        chk("sw.E.cause", rst_cause_o, exp_cause(2'b10));
        tick(5);                                   // E+5
        chk("sw.E5.state", dbg_state_o, S_HOLD);
        chk_rst("sw.E5", 1, 1, 1, 0);
        tick(1);                                   // E+6
        chk("sw.E6.state", dbg_state_o, S_MEM);
        tick(3);                                   // E+9
        chk_rst("sw.E9", 1, 1, 1, 0);
        tick(1);                                   // E+10
        chk_rst("sw.E10", 0, 1, 1, 0);
        tick(7);                                   // E+17
        chk_rst("sw.E17", 0, 0, 1, 0);
        tick(1);                                   // E+18
        chk_rst("sw.E18", 0, 0, 0, 1);
        chk("sw.E18.cause", rst_cause_o, exp_cause(2'b10));

        // 3) Mid-sequence wdt request: periph released, cpu still held.
        rst_i = 1'b1;
        tick(1);
        chk_rst("rst2", 1, 1, 1, 0);
        chk("rst2.cause", rst_cause_o, exp_cause(2'b01));
        rst_i = 1'b0;
        tick(9);                                   // edge 8
        chk_rst("mid.e8", 0, 0, 1, 0);
        chk("mid.e8.state", dbg_state_o, S_CPU);
        wdt_rst_req_i = 1'b1;
        tick(1);                                   // edge 9 = W
        wdt_rst_req_i = 1'b0;
        chk_rst("wdt.W", 1, 1, 1, 0);
        chk("wdt.W.state", dbg_state_o, S_HOLD);
        chk("wdt.W.cause", rst_cause_o, exp_cause(2'b11));
        tick(6);                                   // W+6
        chk("wdt.W6.state", dbg_state_o, S_MEM);
        tick(11);                                  // W+17
        chk_rst("wdt.W17", 0, 0, 1, 0);
        tick(1);                                   // W+18
        chk_rst("wdt.W18", 0, 0, 0, 1);

        // 4) sw and wdt together, then a second sw during the hold.
        sw_rst_req_i  = 1'b1;
        wdt_rst_req_i = 1'b1;
        tick(1);                                   // H
        sw_rst_req_i  = 1'b0;
        wdt_rst_req_i = 1'b0;
        chk("both.H.state", dbg_state_o, S_HOLD);
        chk("both.H.cause", rst_cause_o, exp_cause(2'b11));
        tick(2);                                   // H+2
        sw_rst_req_i = 1'b1;
        tick(1);                                   // H+3, ignored
        sw_rst_req_i = 1'b0;
        chk("both.H3.cause", rst_cause_o, exp_cause(2'b11));
        tick(2);                                   // H+5
        chk("both.H5.state", dbg_state_o, S_HOLD);
        tick(1);                                   // H+6: single hold period
        chk("both.H6.state", dbg_state_o, S_MEM);
        tick(12);                                  // H+18
        chk_rst("both.H18", 0, 0, 0, 1);
        chk("both.H18.state", dbg_state_o, S_RUN);

        // 5) rst_i for one cycle during SW_HOLD.
        sw_rst_req_i = 1'b1;
        tick(1);                                   // H
        sw_rst_req_i = 1'b0;
        chk("hr.H.cause", rst_cause_o, exp_cause(2'b10));
        tick(2);                                   // H+2
        rst_i = 1'b1;
        tick(1);                                   // H+3
        rst_i = 1'b0;
        chk("hr.state", dbg_state_o, S_MEM);
        chk_rst("hr", 1, 1, 1, 0);
        chk("hr.cause", rst_cause_o, exp_cause(2'b01));
        tick(4);                                   // edge 3 after release
        chk_rst("hr.e3", 1, 1, 1, 0);
        tick(1);                                   // edge 4
        chk_rst("hr.e4", 0, 1, 1, 0);
        tick(8);                                   // edge 12
        chk_rst("hr.e12", 0, 0, 0, 1);

        // 6) sw request held high: repeated holds, never released.
        sw_rst_req_i = 1'b1;
        tick(1);
        chk("lvl.state0", dbg_state_o, S_HOLD);
        tick(6);
        chk("lvl.state6", dbg_state_o, S_MEM);
        tick(1);
        chk("lvl.state7", dbg_state_o, S_HOLD);
        seen_done    = 1'b0;
        seen_cpu_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (seq_done_o !== 1'b0) seen_done = 1'b1;
            if (cpu_rst_o !== 1'b1) seen_cpu_low = 1'b1;
        end
        chk("lvl.never_done", seen_done, 1'b0);
        chk("lvl.cpu_held", seen_cpu_low, 1'b0);
        chk("lvl.cause", rst_cause_o, exp_cause(2'b10));
        sw_rst_req_i = 1'b0;
        tick(2);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
